// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: paces a right-shifting SIPO register one shift per CLKS_PER_BIT clocks,
// counts DATA_WIDTH bits per frame, then captures the assembled word and offers it on a
// valid/ready handshake with one word of buffering.
//
// Optional feature macro: SHIFT_FRAME_PARITY_EN
//   defined   - an extra bit period follows the data bits; serial_in is sampled at its end and
//               parity_err reports even-parity failure of {word, parity bit}.
//   undefined - no parity period, serial_in is ignored and parity_err is tied low.

module shift_frame_ctrl #(
  parameter int unsigned DATA_WIDTH   = 5,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  serial_in,
  input  logic [DATA_WIDTH-1:0] sr_data,
  output logic                  sr_shift_en,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  parity_err,
  output logic                  overrun
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 2);

  localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StShift  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StLatch  = 3'd3;
  localparam logic [2:0] StParity = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DivW-1:0]       div_cnt_q, div_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  sr_shift_en_q, sr_shift_en_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  latch_ok;

  // A word may be captured when the buffer is empty or is being drained on this same edge.
  assign latch_ok = !frame_valid_q || frame_ready;

`ifdef SHIFT_FRAME_PARITY_EN
  logic parity_bit_q, parity_bit_d;
  logic parity_err_q, parity_err_d;
`else
  // serial_in only matters during the parity period, which this build does not have.
  logic unused_serial_in;
  assign unused_serial_in = serial_in;
`endif

  // Next-state logic for the frame sequencer and the output buffer.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    busy_d        = busy_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    sr_shift_en_d = 1'b0;
    overrun_d     = 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
    parity_bit_d  = parity_bit_q;
    parity_err_d  = parity_err_q;
`endif

    // Consumer handshake; a capture below on the same edge overrides the clear.
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StShift;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d     = '0;
          bit_cnt_d     = bit_cnt_q + BitW'(1);
          sr_shift_en_d = 1'b1;
          if (bit_cnt_q == BitLast) begin
`ifdef SHIFT_FRAME_PARITY_EN
            state_d = StParity;
`else
            state_d = StSettle;
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end

`ifdef SHIFT_FRAME_PARITY_EN
      // One full bit period with no strobe; the parity bit is sampled at its end.
      StParity: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d    = '0;
          parity_bit_d = serial_in;
          state_d      = StLatch;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
`endif

      // Final strobe is high this cycle; the register updates on the closing edge.
      StSettle: begin
        state_d = StLatch;
      end

      StLatch: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (latch_ok) begin
          frame_data_d  = sr_data;
          frame_valid_d = 1'b1;
`ifdef SHIFT_FRAME_PARITY_EN
          parity_err_d  = ^{sr_data, parity_bit_q};
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything including the held word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      sr_shift_en_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_shift_en_q <= sr_shift_en_d;
      busy_q        <= busy_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef SHIFT_FRAME_PARITY_EN
  // Parity bit capture and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign sr_shift_en = sr_shift_en_q;
  assign busy        = busy_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule
